// File: rtl/dac_jesd204_pkg.sv
// rtl/dac_jesd204_pkg.sv - shared sizing helpers, FSM encoding and slot mapping for the JESD204 TX sample framer
package dac_jesd204_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int calc_dw(input int num_lanes);
      return 32 * num_lanes;
   endfunction

   function automatic int calc_cw(input int num_lanes, input int num_channels);
      return calc_dw(num_lanes) / num_channels;
   endfunction

   function automatic int calc_spc(input int num_lanes, input int num_channels);
      return calc_cw(num_lanes, num_channels) / 16;
   endfunction

   function automatic int calc_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Sample k of channel c lands in 16-bit link slot k*NUM_CHANNELS + c
   function automatic int slot_index(input int k, input int c, input int num_channels);
      return k * num_channels + c;
   endfunction

endpackage

// File: rtl/dac_jesd204_sample_fifo.sv
// rtl/dac_jesd204_sample_fifo.sv - DEPTH x DW synchronous FIFO with occupancy output
module dac_jesd204_sample_fifo
   import dac_jesd204_pkg::*;
#(
   parameter int DW    = 128,
   parameter int DEPTH = 4,
   localparam int PW   = calc_ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] push_data,
   input  logic          push,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   level
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (level == (PW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dac_jesd204_sample_framer.sv
// rtl/dac_jesd204_sample_framer.sv - buffers channel-packed DAC samples and frames them into the JESD204 TX link word
module dac_jesd204_sample_framer
   import dac_jesd204_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int NUM_CHANNELS = 2,
   parameter int DEPTH        = 4,
   parameter int PREFILL      = 2,
   localparam int DW          = calc_dw(NUM_LANES),
   localparam int CW          = calc_cw(NUM_LANES, NUM_CHANNELS),
   localparam int SPC         = calc_spc(NUM_LANES, NUM_CHANNELS),
   localparam int LW          = calc_ptr_w(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] enable,
   input  logic [DW-1:0]           s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [DW-1:0]           tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    underflow,
   output logic [15:0]             underflow_count,
   input  logic                    underflow_clr,
   output logic [LW-1:0]           fifo_level
);

   state_t        state_q;
   state_t        state_d;
   logic          active_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          underflow_ev;
   logic [DW-1:0] fifo_data;
   logic [DW-1:0] framed;
   logic [DW-1:0] tx_next;
   logic [15:0]   ucount_q;
   logic [15:0]   ucount_d;

   assign s_ready         = active_q & ~fifo_full;
   assign tx_valid        = active_q;
   assign underflow_count = ucount_q;

   dac_jesd204_sample_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_data (s_data),
      .push      (s_valid & s_ready),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Interleave channels slot-wise and swap octets so the MSB octet goes out first
   always_comb begin
      framed = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         for (int k = 0; k < SPC; k++) begin
            if (enable[c]) begin
               framed[slot_index(k, c, NUM_CHANNELS)*16 +: 16] =
                  {fifo_data[c*CW + k*16 +: 8], fifo_data[c*CW + k*16 + 8 +: 8]};
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      underflow_ev = 1'b0;
      tx_next      = tx_data;
      case (state_q)
         ST_FILL: begin
            if (tx_ready) tx_next = '0;
            if (fifo_level >= LW'(PREFILL)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (tx_ready) begin
               if (fifo_empty) begin
                  tx_next      = '0;
                  underflow_ev = 1'b1;
                  state_d      = ST_FILL;
               end else begin
                  pop     = 1'b1;
                  tx_next = framed;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   // A clear coinciding with an event still records that event
   always_comb begin
      ucount_d = ucount_q;
      if (underflow_clr)
         ucount_d = underflow_ev ? 16'd1 : 16'd0;
      else if (underflow_ev && (ucount_q != 16'hFFFF))
         ucount_d = ucount_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FILL;
         active_q  <= 1'b0;
         tx_data   <= '0;
         underflow <= 1'b0;
         ucount_q  <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= 1'b1;
         tx_data   <= tx_next;
         underflow <= underflow_ev;
         ucount_q  <= ucount_d;
      end
   end

endmodule
